// File: rtl/popcount_arbiter.sv
// popcount_arbiter: two requesters share one byte-wide ones counter.
// Round-robin arbitration in IDLE, NB cycles of byte popcount in COUNT,
// result held in DONE until the consumer takes it.
// Optional feature macro: POPCNT_PARITY_EN (adds res_parity output).
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   req0_valid/data/ready   requester 0 word handshake (ready combinational)
//   req1_valid/data/ready   requester 1 word handshake (ready combinational)
//   res_valid/id/count      result payload, taken on res_valid & res_ready
//   res_ready               consumer ready
//   busy                    high while counting or holding a result
//   res_parity              XOR of word bits (POPCNT_PARITY_EN only)
module popcount_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count,
  input  logic             res_ready,
  output logic             busy
`ifdef POPCNT_PARITY_EN
  , output logic           res_parity
`endif
);

  localparam int unsigned NB    = WIDTH / 8;
  localparam int unsigned IDX_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   shift, shift_nxt;
  logic [CNT_W-1:0]   acc, acc_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic               id, id_nxt;
  logic               last_grant, last_grant_nxt;
  logic               valid_q, valid_nxt;
  logic               grant0, grant1;

  // Ones count of one byte.
  function automatic logic [3:0] pop8(input logic [7:0] b);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + 4'(b[i]);
    return n;
  endfunction

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    grant0 = req0_valid && (!req1_valid || last_grant);
    grant1 = req1_valid && (!req0_valid || !last_grant);
  end

  assign req0_ready = (state == IDLE) && grant0;
  assign req1_ready = (state == IDLE) && grant1;

  // Next-state and datapath next values.
  always_comb begin
    state_nxt      = state;
    shift_nxt      = shift;
    acc_nxt        = acc;
    idx_nxt        = idx;
    id_nxt         = id;
    last_grant_nxt = last_grant;
    valid_nxt      = valid_q;
    case (state)
      IDLE: begin
        if (grant0 || grant1) begin
          shift_nxt = grant0 ? req0_data : req1_data;
          id_nxt    = grant1;
          acc_nxt   = '0;
          idx_nxt   = '0;
          state_nxt = COUNT;
        end
      end
      COUNT: begin
        acc_nxt   = acc + CNT_W'(pop8(shift[7:0]));
        shift_nxt = shift >> 8;
        idx_nxt   = idx + IDX_W'(1);
        if (idx == IDX_W'(NB - 1)) begin
          state_nxt = DONE;
          valid_nxt = 1'b1;
        end
      end
      DONE: begin
        if (res_ready) begin
          last_grant_nxt = id;
          valid_nxt      = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      shift      <= '0;
      acc        <= '0;
      idx        <= '0;
      id         <= 1'b0;
      last_grant <= 1'b1;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      shift      <= shift_nxt;
      acc        <= acc_nxt;
      idx        <= idx_nxt;
      id         <= id_nxt;
      last_grant <= last_grant_nxt;
      valid_q    <= valid_nxt;
    end
  end

  assign res_valid = valid_q;
  assign res_id    = id;
  assign res_count = acc;
  assign busy      = (state != IDLE);

`ifdef POPCNT_PARITY_EN
  // Parity of the word is the LSB of its ones count.
  assign res_parity = acc[0];
`endif

endmodule

// File: tb/tb_popcount_arbiter.sv
// Scoreboard bench for popcount_arbiter (WIDTH=32, CNT_W=7).
// Drivers push expected results; a negedge monitor pops and compares.
module tb_popcount_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        res_valid, res_id, res_ready, busy;
  logic [6:0]  res_count;
`ifdef POPCNT_PARITY_EN
  logic        res_parity;
`endif

  popcount_arbiter #(.WIDTH(32), .CNT_W(7)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
    .res_ready(res_ready), .busy(busy)
`ifdef POPCNT_PARITY_EN
    , .res_parity(res_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       id;
    logic [6:0] cnt;
    logic       par;
    longint     t_hs;   // handshake time, -1 when not tracked
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   in_res = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic id, input logic [6:0] cnt, input logic [31:0] d,
                          input longint t);
    exp_t e;
    e.id = id; e.cnt = cnt; e.par = ^d; e.t_hs = t;
    q.push_back(e);
  endtask

  // Present a word and wait (bounded) for acceptance.
  task automatic send(input bit id, input logic [31:0] d, input logic [6:0] cnt,
                      input bit push);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    if (id) begin req1_valid = 1'b1; req1_data = d; end
    else    begin req0_valid = 1'b1; req0_data = d; end
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if ((id ? req1_ready : req0_ready) === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
        if (push) push_exp(id, cnt, d, $time);
        #1;
      end else begin
        @(negedge clk);
      end
    end
    if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin @(negedge clk); n++; end
    check(name, q.size(), 0);
  endtask

  // Monitor: compares every presented result against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && res_valid) begin
      if (q.size() == 0) begin
        check("unexpected_res_valid", 1, 0);
      end else begin
        e = q[0];
        if (!in_res && e.t_hs >= 0) check("latency", $time - e.t_hs, 45);
        check("res_count", res_count, e.cnt);
        check("res_id", res_id, e.id);
`ifdef POPCNT_PARITY_EN
        check("res_parity", res_parity, e.par);
`endif
        if (!res_ready) begin
          check("stall_req0_ready", req0_ready, 0);
          check("stall_req1_ready", req1_ready, 0);
          in_res = 1'b1;
        end else begin
          void'(q.pop_front());
          in_res = 1'b0;
        end
      end
    end else begin
      in_res = 1'b0;
    end
  end

  initial begin
    reset_n = 1'b0; res_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; req0_data = '0; req1_data = '0;

    // 1. reset state
    repeat (2) @(negedge clk);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_count", res_count, 0);
    check("rst_res_id", res_id, 0);
    check("rst_busy", busy, 0);
    check("rst_req0_ready", req0_ready, 0);
    check("rst_req1_ready", req1_ready, 0);
    reset_n = 1'b1;
    res_ready = 1'b1;

    // 2. all ones from requester 0
    send(1'b0, 32'hFFFF_FFFF, 7'd32, 1'b1);
    check("busy_in_count", busy, 1);
    drain("drain_t2");

    // 3. requester 1 alone
    send(1'b1, 32'h8000_0001, 7'd2, 1'b1);
    drain("drain_t3a");
    send(1'b1, 32'h0000_0000, 7'd0, 1'b1);
    drain("drain_t3b");

    // 4. both requesters contend: strict alternation starting with 0
    push_exp(1'b0, 7'd16, 32'hA5A5_A5A5, -1);
    push_exp(1'b1, 7'd8,  32'h0F0F_0000, -1);
    push_exp(1'b0, 7'd16, 32'hA5A5_A5A5, -1);
    push_exp(1'b1, 7'd8,  32'h0F0F_0000, -1);
    fork
      begin send(1'b0, 32'hA5A5_A5A5, 7'd16, 1'b0); send(1'b0, 32'hA5A5_A5A5, 7'd16, 1'b0); end
      begin send(1'b1, 32'h0F0F_0000, 7'd8, 1'b0);  send(1'b1, 32'h0F0F_0000, 7'd8, 1'b0);  end
    join
    drain("drain_t4");

    // 5. consumer back-pressure in DONE while requester 1 waits
    res_ready = 1'b0;
    send(1'b0, 32'h1234_5678, 7'd13, 1'b1);
    begin
      int n;
      n = 0;
      while (!res_valid && n < 20) begin @(negedge clk); n++; end
      check("t5_res_valid_seen", res_valid, 1);
    end
    req1_valid = 1'b1; req1_data = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    check("t5_busy_stall", busy, 1);
    req1_valid = 1'b0;
    res_ready = 1'b1;
    drain("drain_t5");

    // 6. reset in the middle of COUNT drops the word
    send(1'b0, 32'hFFFF_0000, 7'd16, 1'b1);
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    q.delete();
    @(negedge clk);
    check("t6_busy_after_rst", busy, 0);
    check("t6_valid_after_rst", res_valid, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t6_no_res_valid", res_valid, 0);
    end
    send(1'b0, 32'h0000_00FF, 7'd8, 1'b1);
    drain("drain_t6");

`ifdef POPCNT_PARITY_EN
    send(1'b0, 32'h0000_0007, 7'd3, 1'b1);
    drain("drain_par_a");
    send(1'b1, 32'hFFFF_FFFF, 7'd32, 1'b1);
    drain("drain_par_b");
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
